// File: rtl/load_store_unit.sv
// Load/store unit: serialises one byte/half/word memory access at a time
// against a synchronous word-wide data memory. Sub-word stores are done as
// read-modify-write. Optional build macro LSU_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into errors instead of truncating low bits.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [29:0] r_idx;
  logic        r_err;

  logic        accept;
  logic        out_of_range;
  logic        misalign;
  logic        err_in;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] merged;

  assign accept       = req_valid && req_ready;
  assign out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err_in = out_of_range || (req_size == 2'b11) || misalign;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the accepted request and its error classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
    end else if (accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_wdata    <= req_wdata;
      r_idx      <= req_addr[31:2];
      r_err      <= err_in;
    end
  end

  // Next-state: errors skip memory, word stores skip the read phase.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (err_in)                                state_next = DONE;
          else if (req_write && req_size == 2'b10)   state_next = WR;
          else                                       state_next = RD;
        end
      end
      RD:      state_next = r_write ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    ld_byte = mem_read_data[{r_lane, 3'b000} +: 8];
    ld_half = mem_read_data[{r_lane[1], 4'b0000} +: 16];
    merged  = mem_read_data;
    unique case (r_size)
      2'b00:   merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: merged = r_wdata;
    endcase
  end

  // Output decode from state and the captured request.
  always_comb begin
    req_ready      = (state == IDLE) && !rst;
    mem_memread    = (state == RD);
    mem_memwrite   = (state == WR);
    mem_addr       = {2'b00, r_idx};
    mem_write_data = (state == WR) ? merged : '0;
    resp_valid     = (state == DONE);
    resp_err       = (state == DONE) && r_err;
    resp_rdata     = '0;
    if ((state == DONE) && !r_err && !r_write) begin
      unique case (r_size)
        2'b00:   resp_rdata = r_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        2'b01:   resp_rdata = r_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        default: resp_rdata = mem_read_data;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed then random
// requests and pushes model expectations; a forked monitor checks responses,
// latency, memory strobes and strobe addresses against them.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data = '0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Attached synchronous memory, preloaded with word i = i.
  logic [31:0] mem [MEM_WORDS];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'(i);
    end else begin
      if (mem_memwrite && mem_addr < MEM_WORDS) mem[mem_addr] <= mem_write_data;
      if (mem_memread && mem_addr < MEM_WORDS) mem_read_data <= mem[mem_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned nrd;
    int unsigned nwr;
    int unsigned acc;
    logic [31:0] idx;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [MEM_WORDS];
  int          checks = 0;
  int          failures = 0;
  logic        abandon = 1'b0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: applies the access rules to ref_mem and returns the response.
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] word, v, mask;
    int unsigned sh;
    e.idx = a >> 2;
    e.rdata = '0; e.nrd = 0; e.nwr = 0; e.acc = 0;
    e.err = (e.idx >= MEM_WORDS) || (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) e.err = 1'b1;
`endif
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    word = ref_mem[e.idx];
    sh   = (sz == 2'b00) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    if (!w) begin
      e.lat = 2; e.nrd = 1;
      if (sz == 2'b10) e.rdata = word;
      else begin
        v = (word >> sh) & mask;
        if (!u) begin
          if (sz == 2'b00) v = (v ^ 32'h80) - 32'h80;
          else             v = (v ^ 32'h8000) - 32'h8000;
        end
        e.rdata = v;
      end
    end else if (sz == 2'b10) begin
      e.lat = 2; e.nwr = 1;
      ref_mem[e.idx] = d;
    end else begin
      e.lat = 3; e.nrd = 1; e.nwr = 1;
      ref_mem[e.idx] = (word & ~(mask << sh)) | ((d & mask) << sh);
    end
    return e;
  endfunction

  task automatic wait_ready(output logic ok);
    int unsigned t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = req_ready;
    if (!ok) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic ok;
    wait_ready(ok);
    if (!ok) return;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    e = model(w, sz, u, a, d);
    e.acc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sbq.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0; wr_cnt = 0;
        continue;
      end
      if ((mem_memread || mem_memwrite) && !abandon) begin
        if (sbq.size() == 0) chk("strobe_unexpected", 32'h1, 32'h0);
        else chk("mem_addr", mem_addr, sbq[0].idx);
        if (mem_memread)  rd_cnt++;
        if (mem_memwrite) wr_cnt++;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) chk("resp_unexpected", 32'h1, 32'h0);
        else begin
          e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", cyc - e.acc, e.lat);
          chk("memread_count", rd_cnt, e.nrd);
          chk("memwrite_count", wr_cnt, e.nwr);
        end
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        chk("idle_resp", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
      end
    end
  endtask

  initial begin
    logic        ok;
    logic [31:0] a;
    int unsigned seen_wr, seen_vld, mism;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = 32'(i);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("rst_resp", {resp_rdata[31:1], resp_rdata[0] | resp_err | resp_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; mem_init = 1'b0;

    fork
      monitor();
    join_none

    // Directed cases.
    issue(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'hAB);
    issue(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    drain();
    chk("word2_after_byte_store", mem[2], 32'h0000AB02);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h55);
    issue(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0);
    issue(1'b1, 2'b01, 1'b1, 32'h3FE, 32'h8001);
    issue(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0);
    drain();

    // Reset during the read phase of a half store.
    wait_ready(ok);
    if (ok) begin
      abandon = 1'b1;
      req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hBEEF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("ready_during_rst", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen_wr = 0; seen_vld = 0;
      @(negedge clk);
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
      for (int k = 0; k < 6; k++) begin
        if (mem_memwrite) seen_wr++;
        if (resp_valid)   seen_vld++;
        @(negedge clk);
      end
      chk("abandon_memwrite", seen_wr, 32'h0);
      chk("abandon_resp", seen_vld, 32'h0);
      chk("abandon_word", mem[8], ref_mem[8]);
      abandon = 1'b0;
    end

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom_range(32'hFFFF_FFFF, MEM_WORDS * 4);
      else                           a = $urandom_range(MEM_WORDS * 4 - 1, 0);
      issue(1'($urandom_range(1, 0)),
            ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0)),
            1'($urandom_range(1, 0)), a, $urandom);
    end
    drain();

    mism = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_memory_mismatches", mism, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
